// File: rtl/aont_decode.sv
// All-or-nothing transform decoder: collects eight data blocks plus one key block,
// recovers the key, then strips the Latin-square mask one block per cycle.
module aont_decode #(
  parameter int messgalen  = 512,
  parameter int noofblocks = 9,
  parameter int lslen      = 16,
  parameter int lslenlog   = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [lslen*lslenlog-1:0]   firstRow,
  input  logic [lslen*lslenlog-1:0]   blk_in,
  input  logic                        blk_valid,
  output logic                        blk_ready,
  output logic [messgalen-1:0]        msg_out,
  output logic                        msg_valid,
  input  logic                        msg_ready,
  output logic                        perm_err
);

  localparam int BW    = lslen * lslenlog;
  localparam int NDATA = noofblocks - 1;
  localparam int CW    = $clog2(noofblocks);
  localparam int IW    = (NDATA > 1) ? $clog2(NDATA) : 1;
  localparam int NSYM  = 1 << lslenlog;

  typedef enum logic [1:0] {COLLECT, DECODE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q;
  logic [IW-1:0]     idx_q;
  logic [BW-1:0]     acc_q;
  logic [BW-1:0]     key_q;
  logic [BW-1:0]     frow_q;
  logic [BW-1:0]     e_mem [NDATA];

  logic              accept;
  logic              first_blk;
  logic              last_blk;
  logic              last_idx;
  logic              dup;
  logic [NSYM-1:0]   seen;
  logic [BW-1:0]     dec_blk;
  logic [lslenlog-1:0] idx_sym;

  assign blk_ready = (state_q == COLLECT);
  assign msg_valid = (state_q == DONE);
  assign accept    = blk_valid & blk_ready;
  assign first_blk = (count_q == '0);
  assign last_blk  = (count_q == CW'(noofblocks - 1));
  assign last_idx  = (idx_q == IW'(NDATA - 1));
  assign idx_sym   = lslenlog'(idx_q);

  // NOTE: blocking '=' is correct here: 'seen' is a combinational scratch
  // variable whose value must update within the loop iteration.
  always_comb begin
    seen = '0;
    dup  = 1'b0;
    for (int c = 0; c < lslen; c++) begin
      if (seen[firstRow[c*lslenlog +: lslenlog]]) dup = 1'b1;
      seen[firstRow[c*lslenlog +: lslenlog]] = 1'b1;
    end
  end

  // Mask symbol is L[(K[j]+idx) mod N][j] = K[j] + idx + F[j], all mod N.
  always_comb begin
    dec_blk = '0;
    for (int j = 0; j < lslen; j++) begin
      dec_blk[j*lslenlog +: lslenlog] = e_mem[idx_q][j*lslenlog +: lslenlog] ^
        (key_q[j*lslenlog +: lslenlog] + idx_sym + frow_q[j*lslenlog +: lslenlog]);
    end
  end

  // NOTE: the block store has no reset; every slot is rewritten before DECODE
  // reads it, and the block count (which is reset) decides what is valid.
  always_ff @(posedge clk) begin
    if (accept && !last_blk) e_mem[count_q[IW-1:0]] <= blk_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (accept && last_blk) state_d = DECODE;
      DECODE:  if (last_idx)           state_d = DONE;
      DONE:    if (msg_ready)          state_d = COLLECT;
      default:                         state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q  <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      key_q    <= '0;
      frow_q   <= '0;
      msg_out  <= '0;
      perm_err <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            acc_q <= acc_q ^ blk_in;
            if (first_blk) begin
              frow_q   <= firstRow;
              perm_err <= dup;
            end
            if (last_blk) begin
              key_q   <= acc_q ^ blk_in;
              count_q <= '0;
              idx_q   <= '0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        DECODE: begin
          msg_out[idx_q*BW +: BW] <= dec_blk;
          idx_q                   <= idx_q + 1'b1;
        end
        DONE: begin
          if (msg_ready) acc_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aont_decode.sv
// Self-checking bench for aont_decode: fixed vectors, random round trips through a
// Latin-square encoder model, back-pressure, held blk_valid and asynchronous reset.
module tb_aont_decode;

  logic         clk;
  logic         rstn;
  logic [63:0]  firstRow;
  logic [63:0]  blk_in;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] msg_out;
  logic         msg_valid;
  logic         msg_ready;
  logic         perm_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] tx_blk [9];

  aont_decode dut (
    .clk       (clk),
    .rstn      (rstn),
    .firstRow  (firstRow),
    .blk_in    (blk_in),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .msg_out   (msg_out),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .perm_err  (perm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  frow;
    logic [63:0]  blk8;
    logic [127:0] exp_lo;
    logic         exp_perm;
  } vec_t;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Explicit Latin square table built from the first row.
  function automatic void build_square(input logic [63:0] frow, output int sq [16][16]);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        sq[r][c] = (r + int'(frow[c*4 +: 4])) % 16;
  endfunction

  function automatic logic [511:0] ref_decode(input logic [63:0] frow);
    int sq [16][16];
    logic [63:0]  key;
    logic [511:0] m;
    build_square(frow, sq);
    key = '0;
    for (int b = 0; b < 9; b++) key ^= tx_blk[b];
    m = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 16; j++)
        m[i*64 + j*4 +: 4] = tx_blk[i][j*4 +: 4] ^ 4'(sq[(int'(key[j*4 +: 4]) + i) % 16][j]);
    return m;
  endfunction

  function automatic logic ref_perm_err(input logic [63:0] frow);
    int cnt [16];
    logic d;
    d = 1'b0;
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int c = 0; c < 16; c++) cnt[frow[c*4 +: 4]]++;
    for (int v = 0; v < 16; v++) if (cnt[v] > 1) d = 1'b1;
    return d;
  endfunction

  // Forward transform: mask each data block, then append K XOR all masked blocks.
  task automatic encode(input logic [511:0] msg, input logic [63:0] key, input logic [63:0] frow);
    int sq [16][16];
    logic [63:0] x;
    build_square(frow, sq);
    x = key;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 16; j++)
        tx_blk[i][j*4 +: 4] = msg[i*64 + j*4 +: 4] ^ 4'(sq[(int'(key[j*4 +: 4]) + i) % 16][j]);
      x ^= tx_blk[i];
    end
    tx_blk[8] = x;
  endtask

  task automatic gen_random(output logic [63:0] frow, output logic [511:0] msg);
    int p [16];
    int k;
    int t;
    logic [63:0] key;
    if ($urandom_range(0, 1) == 1) begin
      for (int i = 0; i < 16; i++) p[i] = i;
      for (int i = 15; i > 0; i--) begin
        k = int'($urandom_range(0, i));
        t = p[i]; p[i] = p[k]; p[k] = t;
      end
      for (int c = 0; c < 16; c++) frow[c*4 +: 4] = 4'(p[c]);
    end else begin
      frow = {$urandom, $urandom};
    end
    for (int w = 0; w < 16; w++) msg[w*32 +: 32] = $urandom;
    key = {$urandom, $urandom};
    encode(msg, key, frow);
  endtask

  // Called at a negedge with the DUT in COLLECT; returns at the first negedge with msg_valid.
  task automatic run_msg(input logic [63:0] frow, input bit gaps, input bit hold_valid,
                         output logic perm0);
    int w;
    int lat;
    perm0 = 1'bx;
    for (int b = 0; b < 9; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          blk_valid = 1'b0;
          blk_in    = {$urandom, $urandom};
          @(negedge clk);
        end
      end
      blk_valid = 1'b1;
      blk_in    = tx_blk[b];
      firstRow  = (b == 0) ? frow : {$urandom, $urandom};
      w = 0;
      while (!blk_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w >= 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: block %0d not accepted within 20 cycles", b);
      end
      @(negedge clk);
      if (b == 0) perm0 = perm_err;
    end
    if (hold_valid) blk_in = {$urandom, $urandom};
    else            blk_valid = 1'b0;
    lat = 0;
    while (!msg_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 512'(lat), 512'(8));
  endtask

  task automatic handshake();
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0;
    check("hs_blk_ready", 512'(blk_ready), 512'(1));
    check("hs_msg_valid", 512'(msg_valid), 512'(0));
  endtask

  vec_t vecs [5];

  initial begin
    logic         p0;
    logic [63:0]  frow;
    logic [511:0] msg;
    logic [511:0] held;
    bit           stable;

    vecs[0] = '{64'hFEDCBA9876543210, 64'h0,
                {64'h0FEDCBA987654321, 64'hFEDCBA9876543210}, 1'b0};
    vecs[1] = '{64'h0000000000000000, 64'h0,
                {64'h1111111111111111, 64'h0000000000000000}, 1'b1};
    vecs[2] = '{64'h0123456789ABCDEF, 64'h0,
                {64'h123456789ABCDEF0, 64'h0123456789ABCDEF}, 1'b0};
    vecs[3] = '{64'hFEDCBA9876543210, 64'hFFFFFFFFFFFFFFFF,
                {64'hFEDCBA9876543210, 64'hEDCBA9876543210F}, 1'b0};
    vecs[4] = '{64'hFEDCBA9876543211, 64'h0,
                {64'h0FEDCBA987654322, 64'hFEDCBA9876543211}, 1'b1};

    rstn      = 1'b0;
    firstRow  = '0;
    blk_in    = '0;
    blk_valid = 1'b0;
    msg_ready = 1'b0;
    #1;
    check("rst_blk_ready", 512'(blk_ready), 512'(1));
    check("rst_msg_valid", 512'(msg_valid), 512'(0));
    check("rst_msg_out",   msg_out,         512'(0));
    check("rst_perm_err",  512'(perm_err),  512'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Fixed vectors: data blocks zero, key block from the table.
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < 8; b++) tx_blk[b] = '0;
      tx_blk[8] = vecs[v].blk8;
      run_msg(vecs[v].frow, 1'b0, 1'b0, p0);
      check($sformatf("vec%0d_perm_blk0", v), 512'(p0), 512'(vecs[v].exp_perm));
      check($sformatf("vec%0d_lo128", v), 512'(msg_out[127:0]), 512'(vecs[v].exp_lo));
      check($sformatf("vec%0d_full", v), msg_out, ref_decode(vecs[v].frow));
      check($sformatf("vec%0d_perm_done", v), 512'(perm_err), 512'(vecs[v].exp_perm));
      handshake();
    end

    // Random round trips with valid gaps.
    for (int n = 0; n < 6; n++) begin
      gen_random(frow, msg);
      run_msg(frow, 1'b1, 1'b0, p0);
      check($sformatf("rand%0d_msg", n), msg_out, msg);
      check($sformatf("rand%0d_perm", n), 512'(p0), 512'(ref_perm_err(frow)));
      handshake();
    end

    // Consumer back-pressure for 20 cycles while blk_valid is asserted.
    gen_random(frow, msg);
    run_msg(frow, 1'b0, 1'b0, p0);
    held   = msg_out;
    stable = 1'b1;
    blk_valid = 1'b1;
    repeat (20) begin
      blk_in = {$urandom, $urandom};
      @(negedge clk);
      if (!msg_valid || blk_ready || msg_out !== held) stable = 1'b0;
    end
    check("stall_stable", 512'(stable), 512'(1));
    check("stall_msg", msg_out, msg);
    blk_valid = 1'b0;
    handshake();
    gen_random(frow, msg);
    run_msg(frow, 1'b1, 1'b0, p0);
    check("after_stall_msg", msg_out, msg);
    handshake();

    // blk_valid held high through DECODE and DONE must not count blocks.
    gen_random(frow, msg);
    run_msg(frow, 1'b0, 1'b1, p0);
    check("held_valid_msg", msg_out, msg);
    repeat (3) begin
      blk_in = {$urandom, $urandom};
      @(negedge clk);
    end
    handshake();
    gen_random(frow, msg);
    run_msg(frow, 1'b0, 1'b0, p0);
    check("held_valid_next_msg", msg_out, msg);
    handshake();

    // Asynchronous reset after five blocks of a duplicate-row message.
    for (int b = 0; b < 5; b++) begin
      blk_valid = 1'b1;
      blk_in    = {$urandom, $urandom};
      firstRow  = 64'h0;
      @(negedge clk);
    end
    blk_valid = 1'b0;
    check("pre_rst_perm", 512'(perm_err), 512'(1));
    #2 rstn = 1'b0;
    #1;
    check("arst_blk_ready", 512'(blk_ready), 512'(1));
    check("arst_msg_valid", 512'(msg_valid), 512'(0));
    check("arst_msg_out",   msg_out,         512'(0));
    check("arst_perm_err",  512'(perm_err),  512'(0));
    @(negedge clk);
    rstn = 1'b1;
    for (int b = 0; b < 9; b++) tx_blk[b] = '0;
    run_msg(64'hFEDCBA9876543210, 1'b0, 1'b0, p0);
    check("post_rst_lo128", 512'(msg_out[127:0]),
          512'({64'h0FEDCBA987654321, 64'hFEDCBA9876543210}));
    check("post_rst_perm", 512'(p0), 512'(0));
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
